fifo_rd_adapter: RTL and testbench

Read-side adapter for the team's synchronous FIFO. It drives the FIFO read port (rd_en, with registered data_out one cycle later) using the empty flag, and re-presents the words as a valid/ready stream for downstream consumers. A 2-entry skid buffer sustains one word per cycle under continuous m_ready. The block also flags protocol errors and counts delivered words.

---
 rtl/fifo_rd_adapter_if.sv | 49 ++++
 rtl/fifo_rd_adapter.sv | 140 ++++++++++++++
 tb/tb_fifo_rd_adapter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_adapter_if.sv
// Signal bundle between the FIFO read port, the adapter and the downstream
// valid/ready consumer. The adapter side uses the master modport.
interface fifo_rd_adapter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                  en;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_underflow;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  busy;
    logic                  err_underflow;
    logic                  clr_err;
    logic [CNT_WIDTH-1:0]  word_cnt;

    modport master (
        input  en,
        input  fifo_empty,
        input  fifo_data_out,
        input  fifo_underflow,
        input  m_ready,
        input  clr_err,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output busy,
        output err_underflow,
        output word_cnt
    );

    modport slave (
        output en,
        output fifo_empty,
        output fifo_data_out,
        output fifo_underflow,
        output m_ready,
        output clr_err,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  busy,
        input  err_underflow,
        input  word_cnt
    );
endinterface

// File: rtl/fifo_rd_adapter.sv
// Drains a synchronous FIFO (one-cycle read latency) into a valid/ready stream
// through a 2-entry skid buffer; flags underflow and counts delivered words.
module fifo_rd_adapter #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_rd_adapter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  rd_pending_q, rd_pending_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  pop_s;
    logic                  push_s;
    logic                  rd_en_s;
    logic [2:0]            level_s;

    // Handshake terms and read-issue decision; level_s is the occupancy the
    // buffer will reach once the pending read lands and this cycle's pop leaves.
    always_comb begin
        pop_s   = (occ_q != 2'd0) && bus.m_ready;
        push_s  = rd_pending_q && !bus.fifo_underflow;
        level_s = {1'b0, occ_q} + {2'b00, rd_pending_q} - {2'b00, pop_s};
        rd_en_s = (state_q == RUN) && !bus.fifo_empty && (level_s < 3'd2);
    end

    // Next-state logic for the drain FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.en) state_d = RUN;
                else        state_d = IDLE;
            end
            RUN: begin
                if (!bus.en) state_d = STOP;
                else         state_d = RUN;
            end
            STOP: begin
                if (bus.en)                                  state_d = RUN;
                else if (!rd_pending_q && (occ_q == 2'd0))   state_d = IDLE;
                else                                         state_d = STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid buffer: head is always the oldest word, tail the younger one
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = bus.fifo_data_out;
                end else begin
                    tail_d = bus.fifo_data_out;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = bus.fifo_data_out;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.fifo_data_out;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // Read tracking, sticky underflow (set beats clear) and delivered count
    always_comb begin
        rd_pending_d = rd_en_s;
        if (rd_pending_q && bus.fifo_underflow) begin
            err_d = 1'b1;
        end else if (bus.clr_err) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        if (pop_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            occ_q        <= 2'd0;
            rd_pending_q <= 1'b0;
            head_q       <= {DATA_WIDTH{1'b0}};
            tail_q       <= {DATA_WIDTH{1'b0}};
            err_q        <= 1'b0;
            cnt_q        <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            rd_pending_q <= rd_pending_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.fifo_rd_en    = rd_en_s;
    assign bus.m_valid       = (occ_q != 2'd0);
    assign bus.m_data        = head_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.err_underflow = err_q;
    assign bus.word_cnt      = cnt_q;

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter: behavioural FIFO, stream monitor,
// a table of drain scenarios and hand-written multi-cycle sequences.
module tb_fifo_rd_adapter;

    logic clk;
    logic rst_n;

    fifo_rd_adapter_if #(.DATA_WIDTH(16), .CNT_WIDTH(4)) bus ();

    fifo_rd_adapter #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data, combinational empty
    logic [15:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        flush  = 1'b0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
            bus.fifo_data_out <= mem[rd_ptr[7:0]];
            rd_ptr            <= rd_ptr + 1;
        end
    end

    // Stream monitor: records delivered words and watches protocol limits
    logic [15:0] got [0:1023];
    int          got_n       = 0;
    int          reads       = 0;
    int          viol        = 0;
    int          outstanding = 0;
    logic        prev_rd     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding = 0;
            prev_rd     = 1'b0;
        end else begin
            if (bus.fifo_rd_en && bus.fifo_empty) viol++;
            if (bus.fifo_rd_en) reads++;
            if (bus.m_valid && bus.m_ready) begin
                got[got_n] = bus.m_data;
                got_n++;
                outstanding--;
            end
            if (bus.fifo_rd_en) outstanding++;
            if (prev_rd && bus.fifo_underflow) outstanding--;
            if (outstanding > 2 || outstanding < 0) viol++;
            prev_rd = bus.fifo_rd_en;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input int start, input int n, input logic [15:0] first);
        for (int i = 0; i < n; i++) begin
            check(name, {16'h0000, got[start + i]}, {16'h0000, first + 16'(i)});
        end
    endtask

    task automatic preload(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = base + 16'(i);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic do_reset();
        bus.en             = 1'b0;
        bus.m_ready        = 1'b0;
        bus.clr_err        = 1'b0;
        bus.fifo_underflow = 1'b0;
        rst_n              = 1'b0;
        flush              = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int start, input int n, input logic [3:0] pat, input int budget);
        int c;
        c = 0;
        while (((got_n - start) < n) && (c < budget)) begin
            bus.m_ready = pat[c % 4];
            @(negedge clk);
            c++;
        end
        check("delivered_count", 32'(got_n - start), 32'(n));
    endtask

    typedef struct {
        int         n_words;
        logic [3:0] ready_pat;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs [0:3];

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int r0;
        int v0;

        vecs[0] = '{8, 4'b1111, 4'd8};
        vecs[1] = '{8, 4'b0101, 4'd8};
        vecs[2] = '{8, 4'b0011, 4'd8};
        vecs[3] = '{5, 4'b0001, 4'd5};

        rst_n = 1'b0;
        do_reset();

        check("rst_rd_en",   {31'd0, bus.fifo_rd_en},    32'd0);
        check("rst_m_valid", {31'd0, bus.m_valid},       32'd0);
        check("rst_m_data",  {16'd0, bus.m_data},        32'd0);
        check("rst_busy",    {31'd0, bus.busy},          32'd0);
        check("rst_err",     {31'd0, bus.err_underflow}, 32'd0);
        check("rst_cnt",     {28'd0, bus.word_cnt},      32'd0);

        // Table: drain 1..n under different ready patterns
        for (int v = 0; v < 4; v++) begin
            do_reset();
            v0    = viol;
            start = got_n;
            preload(vecs[v].n_words, 16'h0001);
            bus.en = 1'b1;
            drain(start, vecs[v].n_words, vecs[v].ready_pat, 200);
            check_seq("tbl_order", start, vecs[v].n_words, 16'h0001);
            check("tbl_word_cnt", {28'd0, bus.word_cnt}, {28'd0, vecs[v].exp_cnt});
            bus.en      = 1'b0;
            bus.m_ready = 1'b1;
            repeat (3) @(negedge clk);
            check("tbl_busy_off", {31'd0, bus.busy}, 32'd0);
            check("tbl_protocol", 32'(viol - v0), 32'd0);
        end

        // Latency and full throughput
        do_reset();
        preload(8, 16'h0001);
        bus.m_ready = 1'b1;
        bus.en      = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 10; k++) begin
            check("thr_rd_en",   {31'd0, bus.fifo_rd_en}, {31'd0, (k < 8)});
            check("thr_m_valid", {31'd0, bus.m_valid},    {31'd0, (k >= 2 && k <= 9)});
            if (k >= 2 && k <= 9) check("thr_m_data", {16'd0, bus.m_data}, 32'(k - 1));
            if (k < 10) @(negedge clk);
        end
        check("thr_word_cnt", {28'd0, bus.word_cnt}, 32'd8);
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        check("thr_busy_off", {31'd0, bus.busy}, 32'd0);

        // Backpressure: only two reads while stalled
        do_reset();
        preload(8, 16'h0001);
        start       = got_n;
        bus.m_ready = 1'b0;
        bus.en      = 1'b1;
        r0          = reads;
        repeat (10) @(negedge clk);
        check("bp_reads",   32'(reads - r0),        32'd2);
        check("bp_m_valid", {31'd0, bus.m_valid},   32'd1);
        check("bp_m_data",  {16'd0, bus.m_data},    32'h0001);
        drain(start, 8, 4'b1111, 100);
        check_seq("bp_order", start, 8, 16'h0001);
        check("bp_no_extra", 32'(got_n - start), 32'd8);

        // en dropped while the read of 0x0003 is issued
        do_reset();
        preload(8, 16'h0001);
        start       = got_n;
        bus.m_ready = 1'b1;
        bus.en      = 1'b1;
        repeat (3) @(negedge clk);
        check("endrop_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
        bus.en = 1'b0;
        @(negedge clk);
        check("endrop_rd_off",  {31'd0, bus.fifo_rd_en}, 32'd0);
        check("endrop_data2",   {16'd0, bus.m_data},     32'h0002);
        @(negedge clk);
        check("endrop_data3",   {16'd0, bus.m_data},     32'h0003);
        check("endrop_valid3",  {31'd0, bus.m_valid},    32'd1);
        @(negedge clk);
        check("endrop_busy_stop", {31'd0, bus.busy},     32'd1);
        check("endrop_drained",   {31'd0, bus.m_valid},  32'd0);
        @(negedge clk);
        check("endrop_busy_idle", {31'd0, bus.busy},     32'd0);
        check_seq("endrop_order", start, 3, 16'h0001);
        check("endrop_count", 32'(got_n - start), 32'd3);

        // Underflow drop, stickiness, clear, and set-beats-clear
        do_reset();
        preload(4, 16'h0001);
        start       = got_n;
        bus.m_ready = 1'b1;
        bus.en      = 1'b1;
        repeat (2) @(negedge clk);
        bus.fifo_underflow = 1'b1;
        @(negedge clk);
        bus.fifo_underflow = 1'b0;
        check("uf_set", {31'd0, bus.err_underflow}, 32'd1);
        drain(start, 3, 4'b1111, 50);
        check_seq("uf_order", start, 3, 16'h0002);
        repeat (3) @(negedge clk);
        check("uf_sticky", {31'd0, bus.err_underflow}, 32'd1);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        check("uf_clear", {31'd0, bus.err_underflow}, 32'd0);
        preload(1, 16'h0005);
        @(negedge clk);
        bus.fifo_underflow = 1'b1;
        bus.clr_err        = 1'b1;
        @(negedge clk);
        bus.fifo_underflow = 1'b0;
        bus.clr_err        = 1'b0;
        check("uf_set_wins", {31'd0, bus.err_underflow}, 32'd1);
        check("uf_dropped",  32'(got_n - start),         32'd3);
        check("uf_cnt",      {28'd0, bus.word_cnt},      32'd3);

        // Asynchronous reset with a word buffered and a read in flight
        bus.m_ready = 1'b0;
        preload(4, 16'h0011);
        repeat (2) @(negedge clk);
        check("ar_pre_valid", {31'd0, bus.m_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_rd_en",   {31'd0, bus.fifo_rd_en},    32'd0);
        check("ar_m_valid", {31'd0, bus.m_valid},       32'd0);
        check("ar_m_data",  {16'd0, bus.m_data},        32'd0);
        check("ar_busy",    {31'd0, bus.busy},          32'd0);
        check("ar_err",     {31'd0, bus.err_underflow}, 32'd0);
        check("ar_cnt",     {28'd0, bus.word_cnt},      32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        check("ar_rel_valid0", {31'd0, bus.m_valid}, 32'd0);
        @(negedge clk);
        check("ar_rel_rd_en",  {31'd0, bus.fifo_rd_en}, 32'd1);
        check("ar_rel_valid1", {31'd0, bus.m_valid},    32'd0);
        @(negedge clk);
        check("ar_rel_valid2", {31'd0, bus.m_valid},    32'd0);
        @(negedge clk);
        check("ar_rel_valid3", {31'd0, bus.m_valid},    32'd1);
        check("ar_rel_data",   {16'd0, bus.m_data},     32'h0013);

        // Counter wrap: 17 pops on a 4-bit counter
        do_reset();
        preload(17, 16'h0100);
        start       = got_n;
        bus.m_ready = 1'b1;
        bus.en      = 1'b1;
        drain(start, 17, 4'b1111, 100);
        check("wrap_cnt", {28'd0, bus.word_cnt}, 32'd1);
        check_seq("wrap_order", start, 17, 16'h0100);
        bus.en = 1'b0;
        repeat (3) @(negedge clk);

        check("protocol_total", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
